// File: rtl/price_pkg.sv
// Shared types and constants for the price frame assembler.
package price_pkg;

  localparam int         PRICE_W           = 32;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame parser states: wait for sync, collect 4 payload bytes, compare checksum.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

endpackage

// File: rtl/price_assembler_if.sv
// Byte-stream input and price/status outputs of the price assembler.
interface price_assembler_if;
  import price_pkg::*;

  logic [7:0]         byte_data;
  logic               byte_valid;
  logic [PRICE_W-1:0] stock_price;
  logic               data_ready;
  logic               frame_error;
  logic [7:0]         err_count;

  // Source of the byte stream / consumer of prices.
  modport master (
    output byte_data, byte_valid,
    input  stock_price, data_ready, frame_error, err_count
  );

  // The assembler itself.
  modport slave (
    input  byte_data, byte_valid,
    output stock_price, data_ready, frame_error, err_count
  );

endinterface

// File: rtl/gap_timer.sv
// Counts consecutive idle cycles inside a frame; flags the idle cycle that
// brings the count to TIMEOUT_CYCLES.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic n_rst,    // synchronous, active-high
  input  logic clear,    // valid byte seen or parser in IDLE
  input  logic enable,   // idle cycle mid-frame
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, expiry restarts from zero, otherwise count idle cycles.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    expired = enable && !clear && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
    count_d = count_q;
    if (clear || expired) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  // NOTE: state is updated with non-blocking assignments so all flops sample the same edge values.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/price_assembler.sv
// Parses SYNC + 4 big-endian payload bytes + XOR checksum frames into a
// registered price, with error pulses and a saturating error counter.
module price_assembler
  import price_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,   // synchronous, active-high
  price_assembler_if.slave bus
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [PRICE_W-1:0] shadow_q, shadow_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic               ready_q, ready_d;
  logic               ferr_q, ferr_d;
  logic [7:0]         errcnt_q, errcnt_d;
  logic               err_event;

  logic gap_clear, gap_enable, gap_expired;

  // The gap counter only runs while a frame is open and no byte arrives.
  assign gap_clear  = bus.byte_valid || (state_q == IDLE);
  assign gap_enable = !bus.byte_valid && (state_q != IDLE);

  gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (gap_clear),
    .enable  (gap_enable),
    .expired (gap_expired)
  );

  // Frame parser next-state, payload capture and status outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    shadow_d  = shadow_q;
    price_d   = price_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    errcnt_d  = errcnt_q;
    err_event = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = 2'd0;
          csum_d  = 8'h00;
        end
      end
      PAYLOAD: begin
        if (bus.byte_valid) begin
          // Shifting in from the right leaves byte 0 in [31:24] after 4 bytes.
          shadow_d = {shadow_q[PRICE_W-9:0], bus.byte_data};
          csum_d   = csum_q ^ bus.byte_data;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (bus.byte_valid) begin
          state_d = IDLE;
          if (bus.byte_data == csum_q) begin
            price_d = shadow_q;
            ready_d = 1'b1;
          end else begin
            err_event = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Only fires on an idle cycle mid-frame, so it never races a byte.
    if (gap_expired) begin
      state_d   = IDLE;
      err_event = 1'b1;
    end

    if (err_event) begin
      ferr_d = 1'b1;
      if (errcnt_q != 8'hFF) begin
        errcnt_d = errcnt_q + 8'd1;
      end
    end
  end

  // State and output registers; reset clears everything including the partial frame.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      csum_q   <= 8'h00;
      shadow_q <= '0;
      price_q  <= '0;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
      errcnt_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      price_q  <= price_d;
      ready_q  <= ready_d;
      ferr_q   <= ferr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.stock_price = price_q;
  assign bus.data_ready  = ready_q;
  assign bus.frame_error = ferr_q;
  assign bus.err_count   = errcnt_q;

endmodule

// File: tb/tb_price_assembler.sv
// Randomized and directed bench for price_assembler against a byte-queue reference model.
module tb_price_assembler;

  localparam int         T    = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic n_rst;

  price_assembler_if bus ();

  price_assembler #(
    .TIMEOUT_CYCLES (T),
    .SYNC_BYTE      (SYNC)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an open frame is a queue of received payload bytes.
  bit          m_open;
  logic [7:0]  m_bytes[$];
  int          m_gap;
  logic [31:0] m_price;
  int          m_err;
  bit          exp_ready;
  bit          exp_ferr;
  int          ready_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_error();
    exp_ferr = 1'b1;
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_step(input logic r, input logic v, input logic [7:0] d);
    logic [7:0] x;
    exp_ready = 1'b0;
    exp_ferr  = 1'b0;
    if (r) begin
      m_open  = 1'b0;
      m_bytes.delete();
      m_gap   = 0;
      m_price = 32'h0;
      m_err   = 0;
      return;
    end
    if (v) begin
      m_gap = 0;
      if (!m_open) begin
        if (d == SYNC) begin
          m_open = 1'b1;
          m_bytes.delete();
        end
      end else if (m_bytes.size() < 4) begin
        m_bytes.push_back(d);
      end else begin
        x = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
        if (d == x) begin
          m_price   = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          exp_ready = 1'b1;
        end else begin
          model_error();
        end
        m_open = 1'b0;
      end
    end else if (m_open) begin
      m_gap++;
      if (m_gap == T) begin
        m_open = 1'b0;
        m_gap  = 0;
        model_error();
      end
    end
  endfunction

  // One clock: apply inputs, advance the model on the edge, compare just after.
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    n_rst          = r;
    bus.byte_valid = v;
    bus.byte_data  = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    if (bus.data_ready === 1'b1) ready_pulses++;
    check("stock_price", bus.stock_price, m_price);
    check("data_ready", 32'(bus.data_ready), 32'(exp_ready));
    check("frame_error", 32'(bus.frame_error), 32'(exp_ferr));
    check("err_count", 32'(bus.err_count), 32'(m_err));
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_list(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  // Full frame with optional checksum corruption and random inter-byte gaps.
  task automatic send_frame(input logic [31:0] p, input bit bad, input int maxgap);
    logic [7:0] c;
    c = p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    if (bad) c = c ^ 8'($urandom_range(1, 255));
    send(SYNC);
    for (int i = 3; i >= 0; i--) begin
      idle($urandom_range(0, maxgap));
      send(p[i*8 +: 8]);
    end
    idle($urandom_range(0, maxgap));
    send(c);
  endtask

  initial begin
    int p0;
    n_rst          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    idle(2);

    // Good frame.
    send_list('{8'hA5, 8'h00, 8'h00, 8'h27, 8'h10, 8'h37});
    check("good_price", bus.stock_price, 32'h00002710);
    idle(1);

    // Bad checksum keeps the previous price.
    send_list('{8'hA5, 8'h00, 8'h00, 8'h27, 8'h10, 8'h38});
    check("bad_err_count", 32'(bus.err_count), 32'd1);
    idle(1);

    // Leading garbage, sync byte inside the payload.
    p0 = ready_pulses;
    send_list('{8'h11, 8'h22, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4});
    idle(2);
    check("sync_in_payload_price", bus.stock_price, 32'hA5000001);
    check("sync_in_payload_pulses", 32'(ready_pulses - p0), 32'd1);

    // Timeout after 8 idle cycles, then a normal frame.
    send_list('{8'hA5, 8'h12, 8'h34});
    idle(T);
    check("timeout_err_count", 32'(bus.err_count), 32'd2);
    send_frame(32'hDEADBEEF, 1'b0, 0);
    check("after_timeout_price", bus.stock_price, 32'hDEADBEEF);

    // A byte arriving on the would-be expiry cycle keeps the frame alive.
    send_list('{8'hA5, 8'h12});
    idle(T - 1);
    send_list('{8'h34, 8'h56, 8'h78});
    send(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    check("edge_gap_price", bus.stock_price, 32'h12345678);

    // Back-to-back frames with no dead cycles.
    send_frame(32'h01020304, 1'b0, 0);
    send_frame(32'hA5A5A5A5, 1'b0, 0);
    check("b2b_price", bus.stock_price, 32'hA5A5A5A5);

    // Saturation, then reset mid-frame, then a good frame.
    for (int i = 0; i < 260; i++) send_frame(32'($urandom), 1'b1, 0);
    check("saturated", 32'(bus.err_count), 32'hFF);
    send_list('{8'hA5, 8'h01});
    tick(1'b1, 1'b0, 8'h00);
    check("reset_price", bus.stock_price, 32'h0);
    idle(3);
    send_frame(32'hCAFEF00D, 1'b0, 0);
    check("post_reset_price", bus.stock_price, 32'hCAFEF00D);

    // Randomized mix of frames, garbage, long gaps and resets.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)       tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (r < 15) send(8'($urandom));
      else if (r < 25) idle($urandom_range(1, 12));
      else if (r < 35) send_frame(32'($urandom), $urandom_range(0, 3) == 0, T + 1);
      else             send_frame(32'($urandom), $urandom_range(0, 3) == 0, 2);
    end
    idle(T + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/price_assembler.md
PRICE_ASSEMBLER -- requirements
Module: price_assembler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000, the number of consecutive idle cycles mid-frame before the frame is aborted.
REQ-002 Parameter: SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-003 Port: clk  input  1  the single clock; all logic is rising-edge.
REQ-004 Port: n_rst  input  1  synchronous, active-high reset; reset is asserted when n_rst=1.
REQ-005 Port: byte_data  input  8  received serial-link byte.
REQ-006 Port: byte_valid  input  1  byte_data is valid this cycle; one byte is consumed per asserted cycle.
REQ-007 Port: stock_price  output  32  last correctly framed price; it feeds the averaging stage.
REQ-008 Port: data_ready  output  1  one-cycle pulse when stock_price has just been updated.
REQ-009 Port: frame_error  output  1  one-cycle pulse on a checksum failure or a timeout.
REQ-010 Port: err_count  output  8  cumulative error count; it saturates.

Function
REQ-011 The block SHALL implement the states IDLE, PAYLOAD and CHECK.
REQ-012 In IDLE: a valid byte equal to SYNC_BYTE SHALL move the block to PAYLOAD with idx=0; any other valid byte SHALL be discarded silently.
REQ-013 In PAYLOAD: each valid byte SHALL be stored big-endian (idx0 -> [31:24] ... idx3 -> [7:0]) and XORed into the running checksum; after idx3 the block SHALL go to CHECK.
REQ-014 In PAYLOAD, a byte equal to SYNC_BYTE SHALL be treated as ordinary data, with no resync.
REQ-015 In CHECK: a valid byte equal to the XOR of the 4 payload bytes SHALL load stock_price from the shadow register and pulse data_ready in the next cycle; the block SHALL then go to IDLE.
REQ-016 In CHECK: on a checksum mismatch, frame_error SHALL pulse in the next cycle, err_count SHALL increment, stock_price SHALL stay unchanged, and the block SHALL go to IDLE.
REQ-017 The idle-gap counter SHALL clear on every valid byte and count cycles with byte_valid=0 while in PAYLOAD or CHECK.
REQ-018 When the idle-gap count reaches TIMEOUT_CYCLES, the block SHALL abort to IDLE, pulse frame_error and increment err_count; the partial frame SHALL be discarded.
REQ-019 A valid byte arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win: it is accepted and no timeout occurs.
REQ-020 The idle-gap counter SHALL be held at 0 in IDLE.
REQ-021 err_count SHALL saturate at 8'hFF and never wrap.
REQ-022 data_ready and frame_error SHALL never be high in the same cycle, and each SHALL last exactly 1 cycle.
REQ-023 Back-to-back frames (byte_valid high every cycle) SHALL be accepted with no dead cycles: the SYNC_BYTE may arrive in the cycle right after the checksum byte.
REQ-024 The latency from the checksum byte being sampled to data_ready=1 SHALL be exactly 1 cycle.

Reset
REQ-025 While n_rst=1 at a clock edge, the following SHALL be forced: state=IDLE, idx=0, checksum=0, gap counter=0, shadow=0, stock_price=32'h0, data_ready=0, frame_error=0, err_count=0.
REQ-026 A reset mid-frame SHALL discard the partial frame and produce no data_ready or frame_error pulse.
REQ-027 The first byte after reset deasserts SHALL be processed in IDLE.

Structure
REQ-028 Package price_pkg SHALL hold the state enum (IDLE, PAYLOAD, CHECK), the SYNC_BYTE default, and PRICE_W=32.
REQ-029 One sub-module, gap_timer, SHALL hold the idle-gap counter, with inputs clear/enable, an output expired, and parameter TIMEOUT_CYCLES.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Good frame: stream A5 00 00 27 10 37 -> stock_price=32'h00002710, data_ready high for 1 cycle, err_count=0.
REQ-032 Bad checksum: stream A5 00 00 27 10 38 -> frame_error for 1 cycle, err_count=1, stock_price keeps its prior value, no data_ready.
REQ-033 Leading garbage plus an in-payload sync: stream 11 22 A5 A5 00 00 01 A4 -> stock_price=32'hA5000001, exactly 1 data_ready pulse.
REQ-034 Timeout with TIMEOUT_CYCLES=8: stream A5 12 34, then 8 idle cycles -> frame_error for 1 cycle, err_count+1; a following good frame is accepted normally.
REQ-035 Saturation and reset: 260 bad frames -> err_count=FF; then assert n_rst mid-frame after A5 01 -> all outputs 0 and no pulses; a good frame after reset -> data_ready.
